// File: rtl/rggen_rtl_pkg.sv
// Shared rggen bus types: transfer direction and slave response status.
package rggen_rtl_pkg;

    typedef enum logic {
        RGGEN_READ  = 1'b0,
        RGGEN_WRITE = 1'b1
    } rggen_direction;

    // Bit 1 set means the access failed.
    typedef enum logic [1:0] {
        RGGEN_OKAY         = 2'b00,
        RGGEN_EXOKAY       = 2'b01,
        RGGEN_SLAVE_ERROR  = 2'b10,
        RGGEN_DECODE_ERROR = 2'b11
    } rggen_status;

endpackage

// File: rtl/rggen_bus_if.sv
// rggen register bus: one request/done handshake per access.
interface rggen_bus_if
    import rggen_rtl_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 16,
    parameter int unsigned BUS_WIDTH     = 32
);
    logic                     request;
    logic [ADDRESS_WIDTH-1:0] address;
    rggen_direction           direction;
    logic [BUS_WIDTH-1:0]     write_data;
    logic [BUS_WIDTH/8-1:0]   write_strobe;
    logic                     done;
    logic [BUS_WIDTH-1:0]     read_data;
    rggen_status              status;

    modport master (
        output request, address, direction, write_data, write_strobe,
        input  done, read_data, status
    );

    modport slave (
        input  request, address, direction, write_data, write_strobe,
        output done, read_data, status
    );
endinterface

// File: rtl/rggen_apb_bridge.sv
// APB3/APB4 completer that turns each APB transfer into one rggen bus request,
// with an optional watchdog that aborts a hung access with a slave error.
module rggen_apb_bridge
    import rggen_rtl_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH  = 16,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 0
)(
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_psel,
    input  logic                      i_penable,
    input  logic [ADDRESS_WIDTH-1:0]  i_paddr,
    input  logic [2:0]                i_pprot,
    input  logic                      i_pwrite,
    input  logic [DATA_WIDTH/8-1:0]   i_pstrb,
    input  logic [DATA_WIDTH-1:0]     i_pwdata,
    output logic                      o_pready,
    output logic [DATA_WIDTH-1:0]     o_prdata,
    output logic                      o_pslverr,
    rggen_bus_if.master               bus_if
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned LSB_WIDTH  = $clog2(STRB_WIDTH);
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_MASK =
        ~ADDRESS_WIDTH'((1 << LSB_WIDTH) - 1);
    localparam int unsigned CNT_WIDTH  =
        (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST =
        CNT_WIDTH'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e                    state_q;
    logic                      request_q;
    logic [ADDRESS_WIDTH-1:0]  address_q;
    rggen_direction            direction_q;
    logic [DATA_WIDTH-1:0]     write_data_q;
    logic [STRB_WIDTH-1:0]     write_strobe_q;
    logic                      pready_q;
    logic                      pslverr_q;
    logic [DATA_WIDTH-1:0]     prdata_q;
    logic [CNT_WIDTH-1:0]      count_q;

    logic                      setup_c;
    logic                      timeout_c;
    logic [1:0]                status_c;
    logic                      unused_c;

    assign setup_c   = i_psel && !i_penable;
    // The watchdog fires in the TIMEOUT_CYCLES-th BUSY cycle if done is still low.
    assign timeout_c = (TIMEOUT_CYCLES != 0) && (count_q >= CNT_LAST);
    assign status_c  = 2'(bus_if.status);
    assign unused_c  = ^{i_pprot, status_c[0]};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q        <= IDLE;
            request_q      <= 1'b0;
            address_q      <= '0;
            direction_q    <= RGGEN_READ;
            write_data_q   <= '0;
            write_strobe_q <= '0;
            pready_q       <= 1'b0;
            pslverr_q      <= 1'b0;
            prdata_q       <= '0;
            count_q        <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    pready_q  <= 1'b0;
                    pslverr_q <= 1'b0;
                    prdata_q  <= '0;
                    if (setup_c) begin
                        address_q      <= i_paddr & ADDR_MASK;
                        direction_q    <= i_pwrite ? RGGEN_WRITE : RGGEN_READ;
                        write_data_q   <= i_pwdata;
                        write_strobe_q <= i_pwrite ? i_pstrb : '1;
                        request_q      <= 1'b1;
                        count_q        <= '0;
                        state_q        <= BUSY;
                    end
                end
                BUSY: begin
                    if (bus_if.done) begin
                        request_q <= 1'b0;
                        pready_q  <= 1'b1;
                        pslverr_q <= status_c[1];
                        prdata_q  <= (direction_q == RGGEN_WRITE) ? '0 : bus_if.read_data;
                        state_q   <= RESP;
                    end else if (timeout_c) begin
                        request_q <= 1'b0;
                        pready_q  <= 1'b1;
                        pslverr_q <= 1'b1;
                        prdata_q  <= '0;
                        state_q   <= RESP;
                    end else if (count_q != CNT_MAX) begin
                        count_q <= count_q + CNT_WIDTH'(1);
                    end
                end
                RESP: begin
                    pready_q  <= 1'b0;
                    pslverr_q <= 1'b0;
                    prdata_q  <= '0;
                    state_q   <= IDLE;
                end
                default: begin
                    request_q <= 1'b0;
                    pready_q  <= 1'b0;
                    pslverr_q <= 1'b0;
                    prdata_q  <= '0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign o_pready  = pready_q;
    assign o_pslverr = pslverr_q;
    assign o_prdata  = prdata_q;

    assign bus_if.request      = request_q;
    assign bus_if.address      = address_q;
    assign bus_if.direction    = direction_q;
    assign bus_if.write_data   = write_data_q;
    assign bus_if.write_strobe = write_strobe_q;

endmodule

// File: tb/tb_rggen_apb_bridge.sv
// Bench for rggen_apb_bridge: directed and random APB transfers against a
// responsive slave whose wait count, data and status are chosen per transfer.
module tb_rggen_apb_bridge;
    import rggen_rtl_pkg::*;

    localparam int unsigned AW  = 16;
    localparam int unsigned DW  = 32;
    localparam int unsigned SW  = DW / 8;
    localparam int unsigned TMO = 8;

    logic           clk;
    logic           rst_n;
    logic           psel;
    logic           penable;
    logic [AW-1:0]  paddr;
    logic [2:0]     pprot;
    logic           pwrite;
    logic [SW-1:0]  pstrb;
    logic [DW-1:0]  pwdata;
    logic           pready;
    logic [DW-1:0]  prdata;
    logic           pslverr;

    rggen_bus_if #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(DW)) bus_if ();

    rggen_apb_bridge #(
        .ADDRESS_WIDTH  (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_psel    (psel),
        .i_penable (penable),
        .i_paddr   (paddr),
        .i_pprot   (pprot),
        .i_pwrite  (pwrite),
        .i_pstrb   (pstrb),
        .i_pwdata  (pwdata),
        .o_pready  (pready),
        .o_prdata  (prdata),
        .o_pslverr (pslverr),
        .bus_if    (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave: asserts done in request cycle slave_wait (0 = first cycle).
    int unsigned    slave_wait;
    logic [DW-1:0]  slave_data;
    rggen_status    slave_status;
    logic           spurious_done;

    int unsigned    req_cyc;
    int unsigned    req_len;
    logic           unstable;
    logic [AW-1:0]  cap_addr;
    rggen_direction cap_dir;
    logic [DW-1:0]  cap_wdata;
    logic [SW-1:0]  cap_strb;

    assign bus_if.done      = spurious_done || (bus_if.request && (req_cyc == slave_wait));
    assign bus_if.read_data = slave_data;
    assign bus_if.status    = slave_status;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_cyc <= 0;
        end else if (bus_if.request) begin
            if (req_cyc == 0) begin
                cap_addr  <= bus_if.address;
                cap_dir   <= bus_if.direction;
                cap_wdata <= bus_if.write_data;
                cap_strb  <= bus_if.write_strobe;
                unstable  <= 1'b0;
            end else if (bus_if.address != cap_addr || bus_if.direction != cap_dir ||
                         bus_if.write_data != cap_wdata || bus_if.write_strobe != cap_strb) begin
                unstable <= 1'b1;
            end
            req_cyc <= req_cyc + 1;
            req_len <= req_cyc + 1;
        end else begin
            req_cyc <= 0;
        end
    end

    int passed;
    int total;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic go_idle();
        @(negedge clk);
        psel    = 1'b0;
        penable = 1'b0;
    endtask

    // One APB transfer, checked against the transfer-level model.
    task automatic xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        input logic [SW-1:0] strb, input int unsigned waitc,
                        input logic [DW-1:0] rdata, input rggen_status st);
        int unsigned cycles;
        bit          timed_out;
        int unsigned exp_cycles;
        logic        exp_err;
        logic [DW-1:0] exp_rdata;
        slave_wait   = waitc;
        slave_data   = rdata;
        slave_status = st;
        @(negedge clk);
        psel    = 1'b1;
        penable = 1'b0;
        paddr   = addr;
        pwrite  = wr;
        pwdata  = wdata;
        pstrb   = strb;
        pprot   = 3'($urandom_range(0, 7));
        cycles  = 1;
        @(negedge clk);
        penable = 1'b1;
        cycles  = 2;
        while (!pready && cycles < 40) begin
            @(negedge clk);
            cycles++;
        end
        timed_out  = (waitc >= TMO);
        exp_cycles = timed_out ? TMO + 2 : waitc + 3;
        exp_err    = timed_out ? 1'b1 : (st == RGGEN_SLAVE_ERROR || st == RGGEN_DECODE_ERROR);
        exp_rdata  = (wr || timed_out) ? '0 : rdata;
        check("pready",    64'(pready), 64'(1'b1));
        check("cycles",    64'(cycles), 64'(exp_cycles));
        check("pslverr",   64'(pslverr), 64'(exp_err));
        check("prdata",    64'(prdata), 64'(exp_rdata));
        check("bus_addr",  64'(cap_addr), 64'(addr - (addr % AW'(SW))));
        check("bus_dir",   64'(cap_dir), 64'(wr));
        check("bus_wdata", 64'(cap_wdata), 64'(wdata));
        check("bus_strb",  64'(cap_strb), 64'(wr ? strb : 4'hF));
        check("req_len",   64'(req_len), 64'(timed_out ? TMO : waitc + 1));
        check("req_stable", 64'(unstable), 64'(1'b0));
    endtask

    initial begin
        passed        = 0;
        total         = 0;
        rst_n         = 1'b0;
        psel          = 1'b0;
        penable       = 1'b0;
        paddr         = '0;
        pprot         = '0;
        pwrite        = 1'b0;
        pstrb         = '0;
        pwdata        = '0;
        spurious_done = 1'b0;
        slave_wait    = 0;
        slave_data    = '0;
        slave_status  = RGGEN_OKAY;

        repeat (3) @(negedge clk);
        check("rst_pready",  64'(pready), 64'(1'b0));
        check("rst_pslverr", 64'(pslverr), 64'(1'b0));
        check("rst_prdata",  64'(prdata), 64'(0));
        check("rst_request", 64'(bus_if.request), 64'(1'b0));
        check("rst_address", 64'(bus_if.address), 64'(0));
        check("rst_dir",     64'(bus_if.direction), 64'(RGGEN_READ));
        check("rst_wdata",   64'(bus_if.write_data), 64'(0));
        check("rst_strb",    64'(bus_if.write_strobe), 64'(0));
        rst_n = 1'b1;

        // Directed transfers from the test list.
        xfer(1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, 0, 32'h0, RGGEN_OKAY);
        xfer(1'b0, 16'h0024, 32'h0, 4'h0, 4, 32'h12345678, RGGEN_OKAY);
        xfer(1'b0, 16'h0103, 32'h0, 4'h0, 1, 32'hCAFEF00D, RGGEN_DECODE_ERROR);
        xfer(1'b0, 16'h0200, 32'h0, 4'h0, 1000, 32'hA5A5A5A5, RGGEN_OKAY);
        xfer(1'b0, 16'h0204, 32'h0, 4'h0, TMO - 1, 32'h5A5A1234, RGGEN_OKAY);
        xfer(1'b1, 16'h0302, 32'h01020304, 4'h6, 2, 32'hFFFFFFFF, RGGEN_SLAVE_ERROR);
        go_idle();
        check("idle_pready", 64'(pready), 64'(1'b0));
        check("idle_prdata", 64'(prdata), 64'(0));

        // Non-setup phase in IDLE plus done outside BUSY: nothing may happen.
        spurious_done = 1'b1;
        @(negedge clk);
        psel    = 1'b1;
        penable = 1'b1;
        repeat (3) @(negedge clk);
        check("noset_request", 64'(bus_if.request), 64'(1'b0));
        check("noset_pready",  64'(pready), 64'(1'b0));
        spurious_done = 1'b0;
        go_idle();

        // Reset in the middle of a stalled access.
        slave_wait = 1000;
        @(negedge clk);
        psel    = 1'b1;
        penable = 1'b0;
        paddr   = 16'h0040;
        pwrite  = 1'b1;
        pwdata  = 32'h11223344;
        pstrb   = 4'h3;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        check("busy_request", 64'(bus_if.request), 64'(1'b1));
        #2 rst_n = 1'b0;
        #1;
        check("arst_request", 64'(bus_if.request), 64'(1'b0));
        check("arst_pready",  64'(pready), 64'(1'b0));
        check("arst_address", 64'(bus_if.address), 64'(0));
        @(negedge clk);
        psel    = 1'b0;
        penable = 1'b0;
        rst_n   = 1'b1;
        xfer(1'b0, 16'h0048, 32'h0, 4'h0, 2, 32'h87654321, RGGEN_EXOKAY);

        // Random transfers, back-to-back unless an idle gap is inserted.
        for (int i = 0; i < 24; i++) begin
            xfer(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom), SW'($urandom),
                 $urandom_range(0, 10), DW'($urandom), rggen_status'($urandom_range(0, 3)));
            if (i % 3 == 2) begin
                go_idle();
                check("gap_pready", 64'(pready), 64'(1'b0));
                check("gap_prdata", 64'(prdata), 64'(0));
            end
        end
        go_idle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
